demux_1x2_buf: RTL and testbench

//   Buffered 1-to-2 demultiplexer for the 16-bit datapath; the steering counterpart of the 2:1 operand mux.

---
 rtl/demux_1x2_buf.sv | 147 ++++++++++++++
 tb/tb_demux_1x2_buf.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1x2_buf.sv
// -----------------------------------------------------------------------------
// demux_1x2_buf
//   Buffered 1-to-2 demultiplexer for the result datapath. A word presented on
//   the input is steered by in_sel into destination A (0) or B (1). Each
//   destination owns a small FIFO, so a stalled consumer never blocks the other.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
//   both 1. The producer holds data/sel stable while valid=1 and ready=0; the
//   FIFOs hold x_valid/x_data stable until the consumer pops. in_ready depends
//   only on in_sel and the selected FIFO's fullness (never on in_valid or the
//   consumer readies), so a full FIFO never passes through in the same cycle.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_data/in_sel        word to steer and its destination (0=A, 1=B)
//   in_valid/in_ready     input handshake
//   a_data/a_valid/a_ready/a_count   destination A head, handshake, occupancy
//   b_data/b_valid/b_ready/b_count   destination B head, handshake, occupancy
//   a_xfers/b_xfers       (DEMUX_STATS_EN only) saturating pop counters
//
// Configuration macro: DEMUX_STATS_EN adds the a_xfers/b_xfers statistics.
// -----------------------------------------------------------------------------
module demux_1x2_buf #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_sel,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           a_data,
   output logic                       a_valid,
   input  logic                       a_ready,
   output logic [$clog2(DEPTH+1)-1:0] a_count,
   output logic [WIDTH-1:0]           b_data,
   output logic                       b_valid,
   input  logic                       b_ready,
   output logic [$clog2(DEPTH+1)-1:0] b_count
`ifdef DEMUX_STATS_EN
   ,
   output logic [15:0]                a_xfers,
   output logic [15:0]                b_xfers
`endif
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int AW = $clog2(DEPTH);

   // Index 0 is destination A, index 1 is destination B.
   logic [WIDTH-1:0] mem_q    [2][DEPTH];
   logic [AW-1:0]    wr_ptr_q [2];
   logic [AW-1:0]    wr_ptr_d [2];
   logic [AW-1:0]    rd_ptr_q [2];
   logic [AW-1:0]    rd_ptr_d [2];
   logic [CW-1:0]    count_q  [2];
   logic [CW-1:0]    count_d  [2];
   logic [1:0]       push;
   logic [1:0]       pop;
   logic [1:0]       full;
   logic [1:0]       out_ready;

   assign out_ready = {b_ready, a_ready};
   assign full[0]   = (count_q[0] == CW'(DEPTH));
   assign full[1]   = (count_q[1] == CW'(DEPTH));
   assign in_ready  = ~full[in_sel];

   always_comb begin
      push = '0;
      pop  = '0;
      for (int i = 0; i < 2; i++) begin
         wr_ptr_d[i] = wr_ptr_q[i];
         rd_ptr_d[i] = rd_ptr_q[i];
         count_d[i]  = count_q[i];
         push[i] = in_valid && in_ready && (in_sel == 1'(i));
         // An empty FIFO has valid=0, so a ready consumer cannot pop it.
         pop[i]  = (count_q[i] != '0) && out_ready[i];
         // DEPTH is a power of two, so the pointers wrap naturally.
         if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + AW'(1);
         if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
         case ({push[i], pop[i]})
            2'b10:   count_d[i] = count_q[i] + CW'(1);
            2'b01:   count_d[i] = count_q[i] - CW'(1);
            default: count_d[i] = count_q[i];
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            count_q[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            wr_ptr_q[i] <= wr_ptr_d[i];
            rd_ptr_q[i] <= rd_ptr_d[i];
            count_q[i]  <= count_d[i];
         end
      end
   end

   // Storage needs no reset: the outputs are masked to 0 while a FIFO is empty.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data;
      end
   end

   assign a_valid = (count_q[0] != '0);
   assign b_valid = (count_q[1] != '0);
   assign a_data  = a_valid ? mem_q[0][rd_ptr_q[0]] : '0;
   assign b_data  = b_valid ? mem_q[1][rd_ptr_q[1]] : '0;
   assign a_count = count_q[0];
   assign b_count = count_q[1];

`ifdef DEMUX_STATS_EN
   logic [15:0] a_xfers_q;
   logic [15:0] b_xfers_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_xfers_q <= '0;
         b_xfers_q <= '0;
      end else begin
         if (pop[0] && (a_xfers_q != 16'hFFFF)) a_xfers_q <= a_xfers_q + 16'd1;
         if (pop[1] && (b_xfers_q != 16'hFFFF)) b_xfers_q <= b_xfers_q + 16'd1;
      end
   end

   assign a_xfers = a_xfers_q;
   assign b_xfers = b_xfers_q;
`else
   // Statistics counters are not built in this configuration.
`endif

`ifndef SYNTHESIS
   // A valid input must carry a known destination.
   always @(posedge clk) begin
      if (rst_n && in_valid) assert (!$isunknown(in_sel));
   end
`endif

endmodule

// File: tb/tb_demux_1x2_buf.sv
// Directed bench for demux_1x2_buf: steering, backpressure, full+pop,
// pointer wrap with a scoreboard, asynchronous reset and optional stats.
module tb_demux_1x2_buf;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [CW-1:0]    a_count;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic [CW-1:0]    b_count;
`ifdef DEMUX_STATS_EN
  logic [15:0]      a_xfers;
  logic [15:0]      b_xfers;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] exp_q[$];

  demux_1x2_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_count  (a_count),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_count  (b_count)
`ifdef DEMUX_STATS_EN
    ,
    .a_xfers  (a_xfers),
    .b_xfers  (b_xfers)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- drivers ----------------
  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WIDTH-1:0] d, input logic s);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    int cyc;
    int npop;
    logic acc;

    rst_n    = 1'b0;
    in_data  = '0;
    in_sel   = 1'b0;
    in_valid = 1'b0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    #2;
    check("rst_a_valid", a_valid, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_a_count", a_count, 0);
    check("rst_b_count", b_count, 0);
    check("rst_a_data", a_data, 0);
    check("rst_in_ready", in_ready, 1);
    #10 rst_n = 1'b1;
    step();

    // Steer: A then B, both consumers ready.
    a_ready  = 1'b1;
    b_ready  = 1'b1;
    in_valid = 1'b1; in_data = 16'h1234; in_sel = 1'b0;
    step();
    check("steer_a_valid", a_valid, 1);
    check("steer_a_data", a_data, 16'h1234);
    in_data = 16'hABCD; in_sel = 1'b1;
    step();
    in_valid = 1'b0;
    check("steer_a_popped", a_count, 0);
    check("steer_b_valid", b_valid, 1);
    check("steer_b_data", b_data, 16'hABCD);
    step();
    check("steer_b_popped", b_count, 0);

    // Backpressure: fill A while its consumer is stalled.
    a_ready = 1'b0;
    b_ready = 1'b0;
    push_word(16'h0001, 1'b0);
    push_word(16'h0002, 1'b0);
    check("full_a_count", a_count, 2);
    in_sel = 1'b0; #1;
    check("full_ready_sel0", in_ready, 0);
    in_sel = 1'b1; #1;
    check("full_ready_sel1", in_ready, 1);
    push_word(16'h0003, 1'b1);
    check("b_accept_count", b_count, 1);
    check("b_accept_data", b_data, 16'h0003);
    check("a_still_count", a_count, 2);
    check("a_still_data", a_data, 16'h0001);

    // Full + pop in the same cycle: no pass-through.
    in_valid = 1'b1; in_data = 16'h0099; in_sel = 1'b0; a_ready = 1'b1;
    #1;
    check("fullpop_in_ready", in_ready, 0);
    step();
    in_valid = 1'b0;
    check("fullpop_a_data", a_data, 16'h0002);
    check("fullpop_a_count", a_count, 1);
    b_ready = 1'b1;
    step();
    check("drain_a_count", a_count, 0);
    check("drain_a_data", a_data, 0);
    check("drain_b_count", b_count, 0);
    b_ready = 1'b0;

    // Wrap: 10 words through A with a toggling consumer.
    idx = 0; cyc = 0; npop = 0;
    while ((idx < 10 || a_valid) && cyc < 100) begin
      in_valid = (idx < 10);
      in_sel   = 1'b0;
      in_data  = 16'h0010 + 16'(idx);
      a_ready  = (cyc % 2 == 0);
      #1;
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(in_data);
      if (a_valid && a_ready) begin
        if (exp_q.size() == 0) check("wrap_extra_pop", a_data, 16'hDEAD);
        else check("wrap_data", a_data, exp_q.pop_front());
        npop++;
      end
      step();
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    a_ready  = 1'b0;
    check("wrap_no_timeout", (cyc < 100), 1);
    check("wrap_pop_total", npop, 10);
    check("wrap_queue_empty", exp_q.size(), 0);
    check("wrap_a_count", a_count, 0);

    // Asynchronous reset with A holding two words.
    push_word(16'h0055, 1'b0);
    push_word(16'h0066, 1'b0);
    check("prerst_a_count", a_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_a_valid", a_valid, 0);
    check("midrst_b_valid", b_valid, 0);
    check("midrst_a_count", a_count, 0);
    check("midrst_a_data", a_data, 0);
    in_sel = 1'b0; #1;
    check("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

`ifdef DEMUX_STATS_EN
    a_ready = 1'b1;
    b_ready = 1'b1;
    check("stats_rst_a", a_xfers, 0);
    push_word(16'h0101, 1'b0);
    push_word(16'h0102, 1'b0);
    push_word(16'h0103, 1'b0);
    push_word(16'h0201, 1'b1);
    step();
    step();
    check("stats_a_xfers", a_xfers, 3);
    check("stats_b_xfers", b_xfers, 1);
    force dut.a_xfers_q = 16'hFFFF;
    #1;
    release dut.a_xfers_q;
    push_word(16'h0104, 1'b0);
    step();
    check("stats_a_saturate", a_xfers, 16'hFFFF);
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
